// File: rtl/fir_sample_sequencer.sv
// Sample sequencer for the FIR core: key/timer requests -> one-cycle o_fir_clk, then BCD conversion of the result.
// Optional FIR_SEQ_PENDING_EN keeps one request that arrives while busy and replays it straight from DONE.
module fir_sample_sequencer #(
    parameter int AUTO_PERIOD = 500,
    parameter int Y_WIDTH     = 12
) (
    input  logic               clk_1kHz,
    input  logic               i_rst_n,
    input  logic               i_step,
    input  logic               i_mode_key,
    input  logic [2:0]         i_xin,
    input  logic [Y_WIDTH-1:0] i_yout,
    output logic               o_fir_clk,
    output logic [2:0]         o_fir_xin,
    output logic [15:0]        o_digits,
    output logic               o_done,
    output logic               o_busy,
    output logic               o_auto,
    output logic [7:0]         o_sample_cnt
);

    localparam int         SH_W        = Y_WIDTH + 16;
    localparam logic [15:0] PERIOD_LAST = 16'(AUTO_PERIOD - 1);
    localparam logic [3:0]  BIT_LAST    = 4'(Y_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        STROBE,
        SETTLE,
        CONVERT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic              step_q, step_d;
    logic              mode_q, mode_d;
    logic              step_rise_q, step_rise_d;
    logic              mode_rise_q, mode_rise_d;
    logic              auto_q, auto_d;
    logic [15:0]       period_q, period_d;
    logic [2:0]        xin_q, xin_d;
    logic [15:0]       digits_q, digits_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [SH_W-1:0]   sh_q, sh_d;
    logic [3:0]        bit_q, bit_d;

    logic              period_hit;
    logic              request;
    logic              pending_take;
    logic [SH_W-1:0]   sh_next;

    // One double-dabble iteration: bias every BCD digit >= 5 by 3, then shift the whole register left.
    function automatic logic [SH_W-1:0] dabble(input logic [SH_W-1:0] v);
        logic [SH_W-1:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (r[Y_WIDTH + 4*i +: 4] >= 4'd5) begin
                r[Y_WIDTH + 4*i +: 4] = r[Y_WIDTH + 4*i +: 4] + 4'd3;
            end
        end
        return r << 1;
    endfunction

    always_comb begin
        step_d      = i_step;
        mode_d      = i_mode_key;
        step_rise_d = i_step & ~step_q;
        mode_rise_d = i_mode_key & ~mode_q;
        auto_d      = auto_q ^ mode_rise_q;

        period_hit  = auto_q && (period_q == PERIOD_LAST);
        request     = auto_q ? period_hit : step_rise_q;

        period_d = period_q + 16'd1;
        if (mode_rise_q || !auto_q || period_hit) begin
            period_d = 16'd0;
        end
    end

`ifdef FIR_SEQ_PENDING_EN
    logic pending_q, pending_d;

    always_comb begin
        pending_d = pending_q;
        if (mode_rise_q) begin
            pending_d = 1'b0;
        end else if (state_q == IDLE || (state_q == DONE && pending_q)) begin
            pending_d = 1'b0;
        end else if (request) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_1kHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_take = pending_q;
`else
    assign pending_take = 1'b0;
`endif

    assign sh_next = dabble(sh_q);

    always_comb begin
        state_d  = state_q;
        xin_d    = xin_q;
        sh_d     = sh_q;
        bit_d    = bit_q;
        digits_d = digits_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (request || pending_take) begin
                    xin_d   = i_xin;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                sh_d    = {16'd0, i_yout};
                bit_d   = 4'd0;
                state_d = CONVERT;
            end
            CONVERT: begin
                sh_d  = sh_next;
                bit_d = bit_q + 4'd1;
                // Results land on entry to DONE so they are already valid while o_done is high.
                if (bit_q == BIT_LAST) begin
                    digits_d = sh_next[SH_W-1 -: 16];
                    cnt_d    = cnt_q + 8'd1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (pending_take) begin
                    xin_d   = i_xin;
                    state_d = STROBE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_1kHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            step_q      <= 1'b0;
            mode_q      <= 1'b0;
            step_rise_q <= 1'b0;
            mode_rise_q <= 1'b0;
            auto_q      <= 1'b0;
            period_q    <= 16'd0;
            xin_q       <= 3'd0;
            digits_q    <= 16'd0;
            cnt_q       <= 8'd0;
            sh_q        <= '0;
            bit_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            mode_q      <= mode_d;
            step_rise_q <= step_rise_d;
            mode_rise_q <= mode_rise_d;
            auto_q      <= auto_d;
            period_q    <= period_d;
            xin_q       <= xin_d;
            digits_q    <= digits_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            bit_q       <= bit_d;
        end
    end

    assign o_fir_clk    = (state_q == STROBE);
    assign o_done       = (state_q == DONE);
    assign o_busy       = (state_q != IDLE);
    assign o_fir_xin    = xin_q;
    assign o_digits     = digits_q;
    assign o_auto       = auto_q;
    assign o_sample_cnt = cnt_q;

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Directed bench for fir_sample_sequencer: table of manual samples plus hand-written reset, auto, hold and wrap sequences.
module tb_fir_sample_sequencer;

    localparam int AUTO_PERIOD = 20;
    localparam int Y_WIDTH     = 12;

    logic               clk_1kHz = 1'b0;
    logic               i_rst_n;
    logic               i_step;
    logic               i_mode_key;
    logic [2:0]         i_xin;
    logic [Y_WIDTH-1:0] i_yout;
    logic               o_fir_clk;
    logic [2:0]         o_fir_xin;
    logic [15:0]        o_digits;
    logic               o_done;
    logic               o_busy;
    logic               o_auto;
    logic [7:0]         o_sample_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [2:0]  xin;
        logic [11:0] yout;
        logic [15:0] digits;
    } vec_t;

    vec_t vecs [8];

    fir_sample_sequencer #(
        .AUTO_PERIOD(AUTO_PERIOD),
        .Y_WIDTH    (Y_WIDTH)
    ) dut (
        .clk_1kHz    (clk_1kHz),
        .i_rst_n     (i_rst_n),
        .i_step      (i_step),
        .i_mode_key  (i_mode_key),
        .i_xin       (i_xin),
        .i_yout      (i_yout),
        .o_fir_clk   (o_fir_clk),
        .o_fir_xin   (o_fir_xin),
        .o_digits    (o_digits),
        .o_done      (o_done),
        .o_busy      (o_busy),
        .o_auto      (o_auto),
        .o_sample_cnt(o_sample_cnt)
    );

    always #5 clk_1kHz = ~clk_1kHz;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyReset();
        i_rst_n    = 1'b0;
        i_step     = 1'b0;
        i_mode_key = 1'b0;
        repeat (3) @(negedge clk_1kHz);
        i_rst_n = 1'b1;
    endtask

    // Step rise driven at k=0; o_fir_clk expected at k=2 and o_done at k=16 (negedges after the drive).
    task automatic applyStimulus(input logic [2:0] xin, input logic [11:0] yout,
                                 output int strobe_k, output int strobes, output logic [2:0] xin_seen,
                                 output int done_k, output logic [15:0] digits_seen);
        strobe_k    = -1;
        strobes     = 0;
        xin_seen    = 3'd0;
        done_k      = -1;
        digits_seen = 16'd0;
        @(negedge clk_1kHz);
        i_xin  = xin;
        i_yout = yout;
        i_step = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_1kHz);
            if (k == 3) i_step = 1'b0;
            if (o_fir_clk) begin
                strobes++;
                if (strobe_k < 0) begin
                    strobe_k = k;
                    xin_seen = o_fir_xin;
                end
            end
            if (o_done && done_k < 0) begin
                done_k      = k;
                digits_seen = o_digits;
            end
        end
    endtask

    initial begin
        int          strobe_k, strobes, done_k, dones, first_k, last_k, bad_gap;
        int          second_k;
        logic [2:0]  xin_seen;
        logic [15:0] digits_seen;
        logic [7:0]  cnt_before;
        int          busy_seen;

        i_xin  = 3'd0;
        i_yout = '0;
        vecs[0] = '{3'd5, 12'd1234, 16'h1234};
        vecs[1] = '{3'd0, 12'd0,    16'h0000};
        vecs[2] = '{3'd7, 12'd4095, 16'h4095};
        vecs[3] = '{3'd2, 12'd1000, 16'h1000};
        vecs[4] = '{3'd1, 12'd9,    16'h0009};
        vecs[5] = '{3'd6, 12'd999,  16'h0999};
        vecs[6] = '{3'd3, 12'd2048, 16'h2048};
        vecs[7] = '{3'd4, 12'd505,  16'h0505};

        applyReset();
        busy_seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_1kHz);
            if (o_busy || o_fir_clk || o_done) busy_seen++;
        end
        checkOutput("idle_activity", busy_seen, 0);
        checkOutput("rst_fir_clk", o_fir_clk, 0);
        checkOutput("rst_fir_xin", o_fir_xin, 0);
        checkOutput("rst_digits", o_digits, 0);
        checkOutput("rst_done", o_done, 0);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_auto", o_auto, 0);
        checkOutput("rst_cnt", o_sample_cnt, 0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].xin, vecs[i].yout, strobe_k, strobes, xin_seen, done_k, digits_seen);
            checkOutput("vec_strobe_time", strobe_k, 2);
            checkOutput("vec_strobe_count", strobes, 1);
            checkOutput("vec_fir_xin", xin_seen, vecs[i].xin);
            checkOutput("vec_done_time", done_k, 16);
            checkOutput("vec_digits", digits_seen, vecs[i].digits);
            checkOutput("vec_digits_hold", o_digits, vecs[i].digits);
            checkOutput("vec_cnt", o_sample_cnt, i + 1);
            checkOutput("vec_busy_after", o_busy, 0);
        end

        // Holding the step key for 50 cycles must yield a single sample.
        cnt_before = o_sample_cnt;
        strobes    = 0;
        @(negedge clk_1kHz);
        i_step = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk_1kHz);
            if (k == 50) i_step = 1'b0;
            if (o_fir_clk) strobes++;
        end
        checkOutput("hold_strobes", strobes, 1);
        checkOutput("hold_cnt", o_sample_cnt, 8'(cnt_before + 8'd1));

        // Second rise lands while the first sample is converting.
        cnt_before = o_sample_cnt;
        strobes    = 0;
        done_k     = -1;
        second_k   = -1;
        @(negedge clk_1kHz);
        i_xin  = 3'd2;
        i_yout = 12'd42;
        i_step = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk_1kHz);
            if (k == 1) i_step = 1'b0;
            if (k == 3) i_step = 1'b1;
            if (k == 4) i_step = 1'b0;
            if (o_fir_clk) begin
                strobes++;
                if (strobes == 2) second_k = k;
            end
            if (o_done && done_k < 0) done_k = k;
        end
        checkOutput("pair_first_done", done_k, 16);
`ifdef FIR_SEQ_PENDING_EN
        checkOutput("pair_strobes", strobes, 2);
        checkOutput("pair_second_strobe", second_k, 17);
        checkOutput("pair_cnt", o_sample_cnt, 8'(cnt_before + 8'd2));
`else
        checkOutput("pair_strobes", strobes, 1);
        checkOutput("pair_second_strobe", second_k, -1);
        checkOutput("pair_cnt", o_sample_cnt, 8'(cnt_before + 8'd1));
`endif

        // Reset while o_fir_clk is high must drop it without waiting for a clock edge.
        @(negedge clk_1kHz);
        i_step = 1'b1;
        for (int k = 1; k <= 2; k++) @(negedge clk_1kHz);
        i_step = 1'b0;
        checkOutput("strobe_before_reset", o_fir_clk, 1);
        #1 i_rst_n = 1'b0;
        #1;
        checkOutput("strobe_async_drop", o_fir_clk, 0);
        @(negedge clk_1kHz);
        i_rst_n = 1'b1;
        repeat (5) @(negedge clk_1kHz);

        // Reset in the middle of CONVERT discards the partial result.
        applyStimulus(3'd1, 12'd777, strobe_k, strobes, xin_seen, done_k, digits_seen);
        @(negedge clk_1kHz);
        i_yout = 12'd777;
        i_step = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_1kHz);
            if (k == 3) i_step = 1'b0;
        end
        checkOutput("convert_busy", o_busy, 1);
        #1 i_rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", o_busy, 0);
        checkOutput("midrst_fir_clk", o_fir_clk, 0);
        checkOutput("midrst_digits", o_digits, 0);
        checkOutput("midrst_cnt", o_sample_cnt, 0);
        @(negedge clk_1kHz);
        i_rst_n = 1'b1;
        dones   = 0;
        strobes = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk_1kHz);
            if (o_done) dones++;
            if (o_fir_clk) strobes++;
        end
        checkOutput("midrst_no_done", dones, 0);
        checkOutput("midrst_no_strobe", strobes, 0);

        // Auto mode: timer strobes every AUTO_PERIOD cycles, step presses ignored.
        i_yout  = 12'd4095;
        strobes = 0;
        dones   = 0;
        first_k = -1;
        last_k  = -1;
        bad_gap = 0;
        @(negedge clk_1kHz);
        i_mode_key = 1'b1;
        for (int k = 1; k <= 105; k++) begin
            @(negedge clk_1kHz);
            if (k == 2) i_mode_key = 1'b0;
            if (k == 5 || k == 70) i_step = 1'b1;
            if (k == 6 || k == 71) i_step = 1'b0;
            if (o_fir_clk) begin
                strobes++;
                if (first_k < 0) first_k = k;
                else if (k - last_k != AUTO_PERIOD) bad_gap++;
                last_k = k;
            end
            if (o_done) dones++;
        end
        checkOutput("auto_mode", o_auto, 1);
        checkOutput("auto_first_strobe", first_k, 22);
        checkOutput("auto_strobes", strobes, 5);
        checkOutput("auto_bad_gaps", bad_gap, 0);
        checkOutput("auto_dones", dones, 4);
        checkOutput("auto_digits", o_digits, 16'h4095);
        checkOutput("auto_cnt", o_sample_cnt, 4);

        @(negedge clk_1kHz);
        i_mode_key = 1'b1;
        @(negedge clk_1kHz);
        i_mode_key = 1'b0;
        repeat (30) @(negedge clk_1kHz);
        checkOutput("manual_mode", o_auto, 0);

        // Sample counter wraps after 256 samples.
        applyReset();
        for (int i = 0; i < 256; i++) begin
            applyStimulus(3'(i), 12'(i), strobe_k, strobes, xin_seen, done_k, digits_seen);
            if (i == 254) checkOutput("wrap_cnt_255", o_sample_cnt, 255);
        end
        checkOutput("wrap_cnt_0", o_sample_cnt, 0);
        checkOutput("wrap_last_digits", o_digits, 16'h0255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
